voice_allocator: RTL and testbench
==================================

VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 Parameter NUM_VOICES, default 16, number of voice slots managed, legal range 2..256.
REQ-002 i_clk  input  1  system clock, all logic on rising edge.
REQ-003 i_reset  input  1  synchronous, active-high reset.
REQ-004 i_note_valid  input  1  note event request, held until accepted.
REQ-005 o_note_ready  output  1  allocator idle and accepting an event.
REQ-006 i_note_on  input  1  event type: 1 = note-on, 0 = note-off.
REQ-007 i_note_num  input  7  MIDI note number.
REQ-008 i_velocity  input  7  MIDI velocity.
REQ-009 i_tuning_code  input  32  DDS phase increment for the note.
REQ-010 o_SPI_flag  output  1  one-cycle voice-update strobe to the voice datapath.
REQ-011 o_SPI_note_status  output  1  1 = gate on, 0 = gate off.
REQ-012 o_SPI_voice_index  output  8  target voice slot.
REQ-013 o_SPI_tuning_code  output  32  phase increment for the target voice.
REQ-014 o_SPI_velocity  output  7  velocity for the target voice.
REQ-015 o_drop  output  1  one-cycle pulse: note-on discarded, no slot available.
REQ-016 o_active_count  output  9  number of active slots.

Function
REQ-017 Each slot holds an active bit and a 7-bit note number.
REQ-018 FSM states IDLE, SCAN, ISSUE; o_note_ready = 1 only in IDLE.
REQ-019 IDLE: on i_note_valid & o_note_ready, capture all event inputs and enter SCAN with scan index 0.
REQ-020 SCAN: examine one slot per cycle, indices 0..NUM_VOICES-1 ascending; always a full scan with no early exit; enter ISSUE after the last slot.
REQ-021 Note-on target priority: (1) active slot with an equal note, i.e. a retrigger; (2) lowest-index inactive slot; (3) full-table handling per REQ-033/034.
REQ-022 Note-off target: active slot with an equal note; if none, the event is ignored: no flag, no drop.
REQ-023 ISSUE, one cycle: pulse o_SPI_flag and drive o_SPI_* from the captured event and the target index; update the table; return to IDLE.
REQ-024 Latency: o_SPI_flag or o_drop high exactly NUM_VOICES+1 cycles after the accept edge; o_note_ready high again the following cycle.
REQ-025 o_SPI_* registered; hold their values until the next ISSUE.
REQ-026 Table update on note-on: slot active = 1, note stored. On note-off: active = 0.
REQ-027 o_active_count updated in the ISSUE cycle; unchanged on retrigger, steal and drop; never exceeds NUM_VOICES.
REQ-028 i_note_valid outside IDLE is ignored, with no capture.
REQ-029 o_SPI_voice_index is zero-extended to 8 bits.

Reset
REQ-030 i_reset high: state IDLE, all active bits 0, steal pointer 0, scan index 0.
REQ-031 While i_reset is high, all outputs are 0, including o_note_ready; o_note_ready goes to 1 on the first cycle after reset deasserts.
REQ-032 Reset during SCAN or ISSUE aborts the event: no flag, no drop, and the table is cleared.

Configuration
REQ-033 With VOICE_ALLOCATOR_STEAL_EN defined, a note-on with no match and no free slot targets the slot at the round-robin steal pointer. The ISSUE is a normal note-on. The pointer then increments, wrapping from NUM_VOICES-1 to 0.
REQ-034 Without VOICE_ALLOCATOR_STEAL_EN, the same case pulses o_drop for one cycle in the ISSUE cycle, with no o_SPI_flag and no table change; no steal pointer is implemented.

Verification (NUM_VOICES=4)
REQ-035 Note-on 60 after reset -> flag at accept+5 cycles, index 0, status 1, tuning/velocity echoed, count 1.
REQ-036 Note-ons 60, 62, then 60 again -> indices 0, 1, 0 (retrigger); count 2.
REQ-037 Note-ons 60..63, note-off 61, note-on 70 -> off on index 1 (status 0), then 70 on index 1; count 4.
REQ-038 Five note-ons 60..64: with STEAL_EN, fifth -> index 0; sixth distinct -> index 1; without STEAL_EN, fifth -> o_drop pulse, no flag, count 4.
REQ-039 Note-off 50 never played -> no flag, no drop, ready returns after 6 cycles.
REQ-040 Reset asserted mid-SCAN -> no flag; next note-on -> index 0, count 1.

Source files
------------

// File: rtl/voice_allocator_if.sv
// voice_allocator_if: note-event request and voice-update bus of the voice allocator
interface voice_allocator_if;
    logic        i_note_valid;
    logic        o_note_ready;
    logic        i_note_on;
    logic [6:0]  i_note_num;
    logic [6:0]  i_velocity;
    logic [31:0] i_tuning_code;
    logic        o_SPI_flag;
    logic        o_SPI_note_status;
    logic [7:0]  o_SPI_voice_index;
    logic [31:0] o_SPI_tuning_code;
    logic [6:0]  o_SPI_velocity;
    logic        o_drop;
    logic [8:0]  o_active_count;

    modport master (
        output i_note_valid, i_note_on, i_note_num, i_velocity, i_tuning_code,
        input  o_note_ready, o_SPI_flag, o_SPI_note_status, o_SPI_voice_index,
               o_SPI_tuning_code, o_SPI_velocity, o_drop, o_active_count
    );

    modport slave (
        input  i_note_valid, i_note_on, i_note_num, i_velocity, i_tuning_code,
        output o_note_ready, o_SPI_flag, o_SPI_note_status, o_SPI_voice_index,
               o_SPI_tuning_code, o_SPI_velocity, o_drop, o_active_count
    );
endinterface

// File: rtl/voice_allocator.sv
// voice_allocator: polyphonic voice slot allocator with a full linear scan per event.
// Optional feature macro VOICE_ALLOCATOR_STEAL_EN: steal a slot round-robin when the
// table is full; without it a note-on to a full table is dropped.
module voice_allocator #(
    parameter int NUM_VOICES = 16
) (
    input logic               i_clk,
    input logic               i_reset,
    voice_allocator_if.slave  bus
);
    localparam int IW = $clog2(NUM_VOICES);
    localparam logic [IW-1:0] LAST = IW'(NUM_VOICES - 1);

    typedef enum logic [1:0] {IDLE, SCAN, ISSUE} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   scan_q;
    logic            match_q, free_q;
    logic [IW-1:0]   match_idx_q, free_idx_q;
    logic            post_q;
    logic            ev_on_q;
    logic [6:0]      ev_note_q, ev_vel_q;
    logic [31:0]     ev_tune_q;
    logic [NUM_VOICES-1:0] active_q;
    logic [6:0]      notes_q [NUM_VOICES];
    logic            flag_q, status_q, drop_q;
    logic [7:0]      vidx_q;
    logic [31:0]     tune_out_q;
    logic [6:0]      vel_out_q;
    logic [8:0]      count_q, count_d;
    logic            accept, hit, issue, drop;
    logic [IW-1:0]   tgt;
`ifdef VOICE_ALLOCATOR_STEAL_EN
    logic [IW-1:0]   steal_q, steal_d;
`endif

    // Ready is held low for one cycle after ISSUE so the result pulse precedes the next accept.
    assign bus.o_note_ready      = (state_q == IDLE) & ~post_q & ~i_reset;
    assign accept                = bus.i_note_valid & bus.o_note_ready;
    assign hit                   = active_q[scan_q] & (notes_q[scan_q] == ev_note_q);
    assign bus.o_SPI_flag        = flag_q;
    assign bus.o_SPI_note_status = status_q;
    assign bus.o_SPI_voice_index = vidx_q;
    assign bus.o_SPI_tuning_code = tune_out_q;
    assign bus.o_SPI_velocity    = vel_out_q;
    assign bus.o_drop            = drop_q;
    assign bus.o_active_count    = count_q;

    // Next-state: accept in IDLE, scan every slot, then one resolve/issue cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = accept ? SCAN : IDLE;
            SCAN:    state_d = (scan_q == LAST) ? ISSUE : SCAN;
            default: state_d = IDLE;
        endcase
    end

    // Target selection from the completed scan: match first, then lowest free, then full-table case.
    always_comb begin
        issue   = 1'b0;
        drop    = 1'b0;
        tgt     = match_idx_q;
        count_d = count_q;
`ifdef VOICE_ALLOCATOR_STEAL_EN
        steal_d = steal_q;
`endif
        if (state_q == ISSUE) begin
            if (ev_on_q) begin
                if (match_q) begin
                    issue = 1'b1;
                end else if (free_q) begin
                    issue   = 1'b1;
                    tgt     = free_idx_q;
                    count_d = count_q + 9'd1;
                end else begin
`ifdef VOICE_ALLOCATOR_STEAL_EN
                    issue   = 1'b1;
                    tgt     = steal_q;
                    steal_d = (steal_q == LAST) ? '0 : steal_q + IW'(1);
`else
                    drop = 1'b1;
`endif
                end
            end else if (match_q) begin
                issue   = 1'b1;
                count_d = count_q - 9'd1;
            end
        end
    end

    // State register and per-slot scan bookkeeping (first match, lowest free slot).
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= IDLE;
            scan_q      <= '0;
            match_q     <= 1'b0;
            free_q      <= 1'b0;
            match_idx_q <= '0;
            free_idx_q  <= '0;
            post_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            post_q  <= (state_q == ISSUE);
            if (accept) begin
                scan_q  <= '0;
                match_q <= 1'b0;
                free_q  <= 1'b0;
            end else if (state_q == SCAN) begin
                scan_q <= (scan_q == LAST) ? '0 : scan_q + IW'(1);
                if (hit & ~match_q) begin
                    match_q     <= 1'b1;
                    match_idx_q <= scan_q;
                end
                if (~active_q[scan_q] & ~free_q) begin
                    free_q     <= 1'b1;
                    free_idx_q <= scan_q;
                end
            end
        end
    end

    // Capture the event on accept; held stable through SCAN and ISSUE.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            ev_on_q   <= bus.i_note_on;
            ev_note_q <= bus.i_note_num;
            ev_vel_q  <= bus.i_velocity;
            ev_tune_q <= bus.i_tuning_code;
        end
    end

    // Slot active bits: set on note-on issue, cleared on note-off issue or reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) active_q <= '0;
        else if (issue) active_q[tgt] <= ev_on_q;
    end

    // Slot note numbers: only meaningful while the slot is active.
    always_ff @(posedge i_clk) begin
        if (issue & ev_on_q) notes_q[tgt] <= ev_note_q;
    end

    // Registered voice-update outputs, strobes and active count.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            flag_q     <= 1'b0;
            drop_q     <= 1'b0;
            status_q   <= 1'b0;
            vidx_q     <= '0;
            tune_out_q <= '0;
            vel_out_q  <= '0;
            count_q    <= '0;
`ifdef VOICE_ALLOCATOR_STEAL_EN
            steal_q    <= '0;
`endif
        end else begin
            flag_q  <= issue;
            drop_q  <= drop;
            count_q <= count_d;
`ifdef VOICE_ALLOCATOR_STEAL_EN
            steal_q <= steal_d;
`endif
            if (issue) begin
                status_q   <= ev_on_q;
                vidx_q     <= 8'(tgt);
                tune_out_q <= ev_tune_q;
                vel_out_q  <= ev_vel_q;
            end
        end
    end
endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: scoreboard bench for voice_allocator with NUM_VOICES=4
module tb_voice_allocator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;

    typedef struct {
        int          kind;
        logic        on;
        int          idx;
        logic [31:0] tune;
        logic [6:0]  vel;
        int          cnt;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    voice_allocator_if bus();

    voice_allocator #(.NUM_VOICES(4)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] tune_of(input logic [6:0] n);
        return 32'h1000_0000 + 32'(n) * 32'h111;
    endfunction

    function automatic logic [6:0] vel_of(input logic [6:0] n);
        return n + 7'd3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every flag or drop pulse pops one expectation.
    always @(negedge clk) begin
        if (bus.o_SPI_flag || bus.o_drop) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", {bus.o_SPI_flag, bus.o_drop}, 2'b00);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_kind", {bus.o_SPI_flag, bus.o_drop}, (e.kind == 1) ? 2'b10 : 2'b01);
                check("latency", cyc, e.cyc);
                check("count", bus.o_active_count, e.cnt);
                if (e.kind == 1) begin
                    check("status", bus.o_SPI_note_status, e.on);
                    check("index", bus.o_SPI_voice_index, e.idx);
                    check("tuning", bus.o_SPI_tuning_code, e.tune);
                    check("velocity", bus.o_SPI_velocity, e.vel);
                end
            end
        end
    end

    task automatic wait_ready;
        int n = 0;
        while (!bus.o_note_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.o_note_ready) check("ready_wait", 0, 1);
    endtask

    // kind: 0 = no pulse, 1 = flag, 2 = drop
    task automatic send(input logic on, input logic [6:0] note, input int kind, input int idx, input int cnt);
        int acc;
        @(negedge clk);
        wait_ready();
        bus.i_note_valid  = 1'b1;
        bus.i_note_on     = on;
        bus.i_note_num    = note;
        bus.i_velocity    = vel_of(note);
        bus.i_tuning_code = tune_of(note);
        @(posedge clk);
        #1;
        acc = cyc;
        bus.i_note_valid = 1'b0;
        if (kind != 0) sb.push_back('{kind, on, idx, tune_of(note), vel_of(note), cnt, acc + 5});
        @(negedge clk);
        wait_ready();
        check("ready_latency", cyc, acc + 6);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        bus.i_note_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", bus.o_note_ready, 0);
        check("rst_flag", bus.o_SPI_flag, 0);
        check("rst_drop", bus.o_drop, 0);
        check("rst_count", bus.o_active_count, 0);
        check("rst_index", bus.o_SPI_voice_index, 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", bus.o_note_ready, 1);
    endtask

    initial begin
        bus.i_note_valid  = 1'b0;
        bus.i_note_on     = 1'b0;
        bus.i_note_num    = '0;
        bus.i_velocity    = '0;
        bus.i_tuning_code = '0;

        do_reset();
        send(1'b1, 7'd60, 1, 0, 1);

        do_reset();
        send(1'b1, 7'd60, 1, 0, 1);
        send(1'b1, 7'd62, 1, 1, 2);
        send(1'b1, 7'd60, 1, 0, 2);

        do_reset();
        for (int i = 0; i < 4; i++) send(1'b1, 7'(60 + i), 1, i, i + 1);
        send(1'b0, 7'd61, 1, 1, 3);
        send(1'b1, 7'd70, 1, 1, 4);

        do_reset();
        for (int i = 0; i < 4; i++) send(1'b1, 7'(60 + i), 1, i, i + 1);
`ifdef VOICE_ALLOCATOR_STEAL_EN
        send(1'b1, 7'd64, 1, 0, 4);
        send(1'b1, 7'd65, 1, 1, 4);
`else
        send(1'b1, 7'd64, 2, 0, 4);
        send(1'b1, 7'd60, 1, 0, 4);
`endif
        send(1'b0, 7'd62, 1, 2, 3);

        do_reset();
        send(1'b0, 7'd50, 0, 0, 0);
        check("ignored_off_count", bus.o_active_count, 0);

        do_reset();
        @(negedge clk);
        wait_ready();
        bus.i_note_valid  = 1'b1;
        bus.i_note_on     = 1'b1;
        bus.i_note_num    = 7'd60;
        bus.i_velocity    = vel_of(7'd60);
        bus.i_tuning_code = tune_of(7'd60);
        @(posedge clk);
        #1;
        bus.i_note_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midscan_rst_ready", bus.o_note_ready, 0);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("midscan_rst_count", bus.o_active_count, 0);
        send(1'b1, 7'd61, 1, 0, 1);

        repeat (10) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
